// File: rtl/multi_bounce.sv
// multi_bounce: N bouncing squares, serial once-per-frame position update, fixed-priority RGB compositing.
// Latency: sx/sy/de -> sdl_*/de_q 1 cycle; update pass runs N cycles starting the cycle after animate.
// Backpressure: cfg_ready is low while a pass runs; `define BOUNCE_COLLIDE_EN builds per-object collision flags.
module multi_bounce #(
    parameter int          CORDW  = 10,
    parameter int          N      = 4,
    parameter int          H_RES  = 640,
    parameter int          V_RES  = 480,
    parameter logic [23:0] BG_RGB = 24'h000000,
    localparam int         IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IW-1:0]    cfg_idx,
    input  logic             cfg_en,
    input  logic [CORDW-1:0] cfg_x,
    input  logic [CORDW-1:0] cfg_y,
    input  logic [CORDW-1:0] cfg_size,
    input  logic [CORDW-1:0] cfg_speed,
    input  logic [23:0]      cfg_rgb,
    output logic [7:0]       sdl_r,
    output logic [7:0]       sdl_g,
    output logic [7:0]       sdl_b,
    output logic             de_q,
    output logic             busy,
    output logic [15:0]      frame_cnt,
    output logic [N-1:0]     collide
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_UPDATE = 1'b1;

    localparam logic [CORDW+1:0] H_LIM = (CORDW+2)'(H_RES);
    localparam logic [CORDW+1:0] V_LIM = (CORDW+2)'(V_RES);

    typedef struct packed {
        logic             dir;
        logic [CORDW-1:0] pos;
    } step_t;

    // pos >= lim-(sz+spd) is evaluated as pos+sz+spd >= lim so nothing can go negative.
    function automatic step_t axis_step(
        input logic [CORDW-1:0] pos,
        input logic [CORDW-1:0] sz,
        input logic [CORDW-1:0] spd,
        input logic             dir,
        input logic [CORDW+1:0] lim
    );
        logic [CORDW+1:0] far_edge;
        step_t            r;
        far_edge = {2'b00, pos} + {2'b00, sz} + {2'b00, spd};
        r.dir    = dir;
        r.pos    = pos;
        if (spd != '0) begin
            if (far_edge >= lim) begin
                r.dir = 1'b1;
                r.pos = pos - spd;
            end else if (pos < spd) begin
                r.dir = 1'b0;
                r.pos = pos + spd;
            end else begin
                r.pos = dir ? (pos - spd) : (pos + spd);
            end
        end
        return r;
    endfunction

    logic [0:0]       state;
    logic [IW-1:0]    idx;
    logic             animate;
    logic             cfg_fire;

    logic [N-1:0]     en;
    logic [N-1:0]     dx;
    logic [N-1:0]     dy;
    logic [CORDW-1:0] pos_x [N];
    logic [CORDW-1:0] pos_y [N];
    logic [CORDW-1:0] size  [N];
    logic [CORDW-1:0] speed [N];
    logic [23:0]      rgb   [N];

    logic             cur_en;
    logic [CORDW-1:0] cur_x;
    logic [CORDW-1:0] cur_y;
    logic [CORDW-1:0] cur_sz;
    logic [CORDW-1:0] cur_sp;
    step_t            nx;
    step_t            ny;

    logic [N-1:0]     hit;
    logic [23:0]      pix;

    assign animate   = (sy == CORDW'(V_RES)) && (sx == '0) && run;
    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state == ST_UPDATE);
    assign cfg_fire  = cfg_valid && cfg_ready;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (animate) begin
                        state <= ST_UPDATE;
                        idx   <= '0;
                    end
                end
                ST_UPDATE: begin
                    if (idx == IW'(N-1)) begin
                        state     <= ST_IDLE;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // One shared update unit, time-multiplexed across objects by idx.
    assign cur_en = en[idx];
    assign cur_x  = pos_x[idx];
    assign cur_y  = pos_y[idx];
    assign cur_sz = size[idx];
    assign cur_sp = speed[idx];
    assign nx     = axis_step(cur_x, cur_sz, cur_sp, dx[idx], H_LIM);
    assign ny     = axis_step(cur_y, cur_sz, cur_sp, dy[idx], V_LIM);

    // Writes only land in IDLE and the pass only runs in UPDATE, so the two never collide.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            en <= '0;
            dx <= '0;
            dy <= '0;
            for (int i = 0; i < N; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                size[i]  <= '0;
                speed[i] <= '0;
                rgb[i]   <= '0;
            end
        end else if (cfg_fire) begin
            for (int i = 0; i < N; i++) begin
                if (cfg_idx == IW'(i)) begin
                    en[i]    <= cfg_en;
                    dx[i]    <= 1'b0;
                    dy[i]    <= 1'b0;
                    pos_x[i] <= cfg_x;
                    pos_y[i] <= cfg_y;
                    size[i]  <= cfg_size;
                    speed[i] <= cfg_speed;
                    rgb[i]   <= cfg_rgb;
                end
            end
        end else if ((state == ST_UPDATE) && cur_en) begin
            pos_x[idx] <= nx.pos;
            pos_y[idx] <= ny.pos;
            dx[idx]    <= nx.dir;
            dy[idx]    <= ny.dir;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = en[i]
                  && (sx >= pos_x[i]) && ({1'b0, sx} < ({1'b0, pos_x[i]} + {1'b0, size[i]}))
                  && (sy >= pos_y[i]) && ({1'b0, sy} < ({1'b0, pos_y[i]} + {1'b0, size[i]}));
        end
    end

    // Walk from highest to lowest index so the lowest hitting index overrides.
    always_comb begin
        pix = BG_RGB;
        for (int i = N-1; i >= 0; i--) begin
            if (hit[i]) pix = rgb[i];
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            de_q  <= 1'b0;
            sdl_r <= '0;
            sdl_g <= '0;
            sdl_b <= '0;
        end else begin
            de_q                  <= de;
            {sdl_r, sdl_g, sdl_b} <= de ? pix : 24'h000000;
        end
    end

`ifdef BOUNCE_COLLIDE_EN
    logic [N-1:0] acc;
    logic [N-1:0] acc_set;

    always_comb begin
        acc_set = '0;
        for (int i = 0; i < N; i++) begin
            acc_set[i] = de && hit[i] && ((hit & ~(N'(1) << i)) != '0);
        end
    end

    // collide reports the frame that just ended; acc restarts for the next one.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            collide <= '0;
        end else if (animate) begin
            collide <= acc;
            acc     <= '0;
        end else begin
            acc <= acc | acc_set;
        end
    end
`else
    assign collide = '0;
`endif

endmodule

// File: tb/tb_multi_bounce.sv
// Randomized bench for multi_bounce against a frame-level behavioural model of objects and pixels.
module tb_multi_bounce;

    localparam int          CORDW = 10;
    localparam int          N     = 4;
    localparam int          IW    = 2;
    localparam int          H_RES = 640;
    localparam int          V_RES = 480;
    localparam logic [23:0] BG    = 24'h102030;

    logic             clk_pix = 1'b0;
    logic             rst_n;
    logic [CORDW-1:0] sx, sy;
    logic             de, run;
    logic             cfg_valid, cfg_ready;
    logic [IW-1:0]    cfg_idx;
    logic             cfg_en;
    logic [CORDW-1:0] cfg_x, cfg_y, cfg_size, cfg_speed;
    logic [23:0]      cfg_rgb;
    logic [7:0]       sdl_r, sdl_g, sdl_b;
    logic             de_q, busy;
    logic [15:0]      frame_cnt;
    logic [N-1:0]     collide;

    multi_bounce #(
        .CORDW(CORDW), .N(N), .H_RES(H_RES), .V_RES(V_RES), .BG_RGB(BG)
    ) dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .sx(sx), .sy(sy), .de(de), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_size(cfg_size), .cfg_speed(cfg_speed),
        .cfg_rgb(cfg_rgb), .sdl_r(sdl_r), .sdl_g(sdl_g), .sdl_b(sdl_b), .de_q(de_q),
        .busy(busy), .frame_cnt(frame_cnt), .collide(collide)
    );

    always #5 clk_pix = ~clk_pix;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_en [N], m_x [N], m_y [N], m_sz [N], m_sp [N], m_dx [N], m_dy [N];
    logic [23:0] m_rgb [N];
    int          fc_exp = 0;
    logic [N-1:0] acc_m = '0;
    logic [N-1:0] col_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic model_write(input int i, input int e, input int x, input int y,
                               input int s, input int sp, input logic [23:0] c);
        if (i < N) begin
            m_en[i] = e;  m_x[i] = x;  m_y[i] = y;  m_sz[i] = s;  m_sp[i] = sp;
            m_rgb[i] = c; m_dx[i] = 0; m_dy[i] = 0;
        end
    endtask

    // Bounce rule on one axis: near the far wall go back, near zero go forward, otherwise keep going.
    task automatic axis(inout int p, inout int d, input int s, input int sp, input int res);
        if (sp != 0) begin
            if (p >= res - (s + sp)) begin
                d = 1; p = p - sp;
            end else if (p < sp) begin
                d = 0; p = p + sp;
            end else begin
                p = (d != 0) ? p - sp : p + sp;
            end
            p = p & ((1 << CORDW) - 1);
        end
    endtask

    task automatic model_frame();
        int p, d;
        for (int i = 0; i < N; i++) begin
            if (m_en[i] != 0) begin
                p = m_x[i]; d = m_dx[i]; axis(p, d, m_sz[i], m_sp[i], H_RES); m_x[i] = p; m_dx[i] = d;
                p = m_y[i]; d = m_dy[i]; axis(p, d, m_sz[i], m_sp[i], V_RES); m_y[i] = p; m_dy[i] = d;
            end
        end
        fc_exp++;
`ifdef BOUNCE_COLLIDE_EN
        col_m = acc_m;
`endif
        acc_m = '0;
    endtask

    task automatic cfg_write(input int i, input int e, input int x, input int y,
                             input int s, input int sp, input logic [23:0] c, output int waits);
        bit ok, done;
        cfg_idx = IW'(i); cfg_en = (e != 0); cfg_x = CORDW'(x); cfg_y = CORDW'(y);
        cfg_size = CORDW'(s); cfg_speed = CORDW'(sp); cfg_rgb = c;
        cfg_valid = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            ok = cfg_ready;
            step();
            waits++;
            if (ok) done = 1'b1;
        end
        cfg_valid = 1'b0;
        check("cfg_accept", 32'(done), 32'd1);
        model_write(i, e, x, y, s, sp, c);
    endtask

    task automatic probe(input int px, input int py, input bit d);
        logic [23:0]  exp;
        logic [N-1:0] hits;
        sx = CORDW'(px); sy = CORDW'(py); de = d;
        step();
        hits = '0;
        for (int i = 0; i < N; i++)
            hits[i] = (m_en[i] != 0) && px >= m_x[i] && px < m_x[i] + m_sz[i]
                      && py >= m_y[i] && py < m_y[i] + m_sz[i];
        exp = BG;
        for (int i = 0; i < N; i++) begin
            if (hits[i]) begin
                exp = m_rgb[i];
                break;
            end
        end
        if (!d) exp = 24'h0;
        check($sformatf("pix(%0d,%0d)", px, py), 32'({sdl_r, sdl_g, sdl_b}), 32'(exp));
        check("de_q", 32'(de_q), 32'(d));
        if (d && $countones(hits) >= 2) acc_m = acc_m | hits;
    endtask

    task automatic anim(input bit r);
        int nb;
        sx = '0; sy = CORDW'(V_RES); de = 1'b0; run = r;
        step();
        sy = CORDW'(V_RES + 1);
        run = 1'($urandom % 2);
        nb = 0;
        for (int c = 0; c < N + 2; c++) begin
            if (busy) nb++;
            check("cfg_ready_vs_busy", 32'(cfg_ready), 32'(!busy));
            step();
        end
        check("busy_cycles", 32'(nb), r ? 32'(N) : 32'd0);
        if (r) model_frame();
        check("frame_cnt", 32'(frame_cnt), 32'(fc_exp[15:0]));
        check("collide", 32'(collide), 32'(col_m));
    endtask

    task automatic probe_obj(input int k);
        int px [4];
        int py [4];
        px[0] = m_x[k];             py[0] = m_y[k];
        px[1] = m_x[k] + m_sz[k] - 1; py[1] = m_y[k] + m_sz[k] - 1;
        px[2] = m_x[k] + m_sz[k];   py[2] = m_y[k];
        px[3] = m_x[k] - 1;         py[3] = m_y[k] + m_sz[k];
        for (int j = 0; j < 4; j++) begin
            if (px[j] >= 0 && px[j] < 1024 && py[j] >= 0 && py[j] < 1024
                && !(px[j] == 0 && py[j] == V_RES))
                probe(px[j], py[j], 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < N; i++) model_write(i, 0, 0, 0, 0, 0, 24'h0);
        rst_n = 1'b0; sx = 10'd5; sy = 10'd5; de = 1'b1; run = 1'b1;
        cfg_valid = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_x = '0; cfg_y = '0;
        cfg_size = '0; cfg_speed = '0; cfg_rgb = '0;
        repeat (5) step();
        check("rst_rgb", 32'({sdl_r, sdl_g, sdl_b}), 32'd0);
        check("rst_de_q", 32'(de_q), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_collide", 32'(collide), 32'd0);
        rst_n = 1'b1; de = 1'b0; run = 1'b0;
        step();

        // Basic draw
        cfg_write(0, 1, 10, 10, 100, 0, 24'hFF0000, w);
        probe(10, 10, 1'b1);
        probe(110, 10, 1'b1);
        probe(109, 109, 1'b1);
        probe(10, 10, 1'b0);

        // Right-edge bounce, then continued leftward motion from the stored direction
        cfg_write(0, 1, 535, 10, 100, 5, 24'hFF0000, w);
        anim(1'b1);
        probe(530, 15, 1'b1); probe(529, 15, 1'b1); probe(629, 15, 1'b1); probe(630, 15, 1'b1);
        anim(1'b1);
        probe(525, 20, 1'b1); probe(524, 20, 1'b1);

        // Left-edge bounce
        cfg_write(0, 1, 4, 200, 50, 5, 24'h00FF00, w);
        anim(1'b1);
        probe(9, 205, 1'b1); probe(8, 205, 1'b1);
        anim(1'b1);
        probe(14, 210, 1'b1); probe(13, 210, 1'b1);

        // Write held off by a running pass completes right after it
        sx = '0; sy = CORDW'(V_RES); de = 1'b0; run = 1'b1;
        step();
        sy = CORDW'(V_RES + 1);
        model_frame();
        cfg_write(1, 1, 300, 300, 40, 2, 24'h0000FF, w);
        check("cfg_pending_wait", 32'(w), 32'(N + 1));
        check("frame_cnt_pending", 32'(frame_cnt), 32'(fc_exp[15:0]));
        probe(300, 300, 1'b1); probe(299, 300, 1'b1);

        // Write in the animate cycle is used by the pass that follows
        cfg_idx = 2'd2; cfg_en = 1'b1; cfg_x = 10'd100; cfg_y = 10'd100;
        cfg_size = 10'd20; cfg_speed = 10'd3; cfg_rgb = 24'h00FFFF; cfg_valid = 1'b1;
        sx = '0; sy = CORDW'(V_RES); de = 1'b0; run = 1'b1;
        step();
        cfg_valid = 1'b0; sy = CORDW'(V_RES + 1);
        model_write(2, 1, 100, 100, 20, 3, 24'h00FFFF);
        model_frame();
        repeat (N + 1) step();
        check("frame_cnt_same_cycle", 32'(frame_cnt), 32'(fc_exp[15:0]));
        probe(103, 103, 1'b1); probe(102, 103, 1'b1); probe(302, 302, 1'b1);

        // Priority and collision
        cfg_write(0, 1, 40, 40, 30, 0, 24'hFF0000, w);
        cfg_write(1, 1, 45, 45, 30, 0, 24'h0000FF, w);
        probe(50, 50, 1'b1); probe(72, 72, 1'b1);
        anim(1'b1);
`ifdef BOUNCE_COLLIDE_EN
        check("collide_overlap", 32'(collide), 32'h3);
`endif
        cfg_write(1, 1, 400, 300, 30, 0, 24'h0000FF, w);
        probe(50, 50, 1'b1); probe(410, 310, 1'b1);
        anim(1'b1);
`ifdef BOUNCE_COLLIDE_EN
        check("collide_cleared", 32'(collide), 32'h0);
`endif

        // Pause: three frames with run low
        repeat (3) anim(1'b0);
        probe(103, 103, 1'b1); probe(14, 210, 1'b1);

        // Randomized frames
        for (int it = 0; it < 30; it++) begin
            if ($urandom % 2 == 0)
                cfg_write($urandom_range(0, N - 1), ($urandom % 4) != 0,
                          $urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1),
                          $urandom_range(1, 120), $urandom_range(0, 12), 24'($urandom), w);
            for (int p = 0; p < 8; p++)
                probe($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1), ($urandom % 4) != 0);
            probe_obj($urandom_range(0, N - 1));
            anim(($urandom % 5) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
